// File: rtl/blowfish_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : blowfish_round_seq
// Description : Sequencer for an iterated Blowfish datapath. Accepts one
//               64-bit block, steps it through 16 passes of a shared
//               single-round unit, runs one post-processing pass and holds
//               the registered result until downstream takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module blowfish_round_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [63:0] Plain_in,
    input  logic        Decrypt_in,
    output logic [63:0] Rnd_data_out,
    output logic [4:0]  Rnd_idx_out,
    input  logic [63:0] Rnd_data_in,
    output logic [63:0] Post_data_out,
    input  logic [63:0] Post_data_in,
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic [63:0] Cipher_out,
    output logic        Busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_ROUND = 4'd15;

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_work;
    logic [63:0] r_cipher;
    logic [3:0]  r_k;
    logic        r_dec;
    logic        w_accept;
    logic [3:0]  w_idx;

    // A block is taken only while idle; no overlap with a block in flight.
    assign w_accept = In_valid && (r_state == S_IDLE);

    // Decrypt walks the subkeys backwards, using the direction latched at acceptance.
    assign w_idx = r_dec ? (c_LAST_ROUND - r_k) : r_k;

    // The working block feeds both shared units continuously.
    assign Rnd_data_out  = r_work;
    assign Post_data_out = r_work;
    assign Cipher_out    = r_cipher;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        w_next      = r_state;
        In_ready    = 1'b0;
        Out_valid   = 1'b0;
        Busy        = 1'b1;
        Rnd_idx_out = 5'd0;
        case (r_state)
            S_IDLE: begin
                In_ready = 1'b1;
                Busy     = 1'b0;
                if (In_valid) begin
                    w_next = S_ROUND;
                end
            end
            S_ROUND: begin
                Rnd_idx_out = {1'b0, w_idx};
                if (r_k == c_LAST_ROUND) begin
                    w_next = S_POST;
                end
            end
            S_POST: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                Out_valid = 1'b1;
                if (Out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Working block, round counter and direction: loaded on acceptance, iterated in ROUND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= 64'd0;
            r_k    <= 4'd0;
            r_dec  <= 1'b0;
        end else if (w_accept) begin
            r_work <= Plain_in;
            r_k    <= 4'd0;
            r_dec  <= Decrypt_in;
        end else if (r_state == S_ROUND) begin
            r_work <= Rnd_data_in;
            r_k    <= r_k + 4'd1;
        end
    end

    // Result register: captured once in POST, held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cipher <= 64'd0;
        end else if (r_state == S_POST) begin
            r_cipher <= Post_data_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blowfish_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_blowfish_round_seq
// Description : Directed self-checking bench for blowfish_round_seq. The round
//               unit is modelled as XOR with the round index and the post unit
//               as a 32-bit half swap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blowfish_round_seq;

    logic        clk;
    logic        rst_n;
    logic        In_valid;
    logic        In_ready;
    logic [63:0] Plain_in;
    logic        Decrypt_in;
    logic [63:0] Rnd_data_out;
    logic [4:0]  Rnd_idx_out;
    logic [63:0] Rnd_data_in;
    logic [63:0] Post_data_out;
    logic [63:0] Post_data_in;
    logic        Out_valid;
    logic        Out_ready;
    logic [63:0] Cipher_out;
    logic        Busy;

    int          checks;
    int          failures;
    logic [63:0] r_expw;
    int          n_acc;
    int          n_out;
    int          acc_cyc [2];
    logic [63:0] outs [2];
    logic        acc_now;
    int          ov_seen;

    blowfish_round_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .In_valid      (In_valid),
        .In_ready      (In_ready),
        .Plain_in      (Plain_in),
        .Decrypt_in    (Decrypt_in),
        .Rnd_data_out  (Rnd_data_out),
        .Rnd_idx_out   (Rnd_idx_out),
        .Rnd_data_in   (Rnd_data_in),
        .Post_data_out (Post_data_out),
        .Post_data_in  (Post_data_in),
        .Out_valid     (Out_valid),
        .Out_ready     (Out_ready),
        .Cipher_out    (Cipher_out),
        .Busy          (Busy)
    );

    // Behavioural stand-ins for the shared round and post-processing units.
    assign Rnd_data_in  = Rnd_data_out ^ {59'd0, Rnd_idx_out};
    assign Post_data_in = {Post_data_out[31:0], Post_data_out[63:32]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one block at a negedge while idle; returns at the negedge after acceptance (k=0).
    task automatic accept(input logic [63:0] plain, input logic dec);
        int waited;
        waited = 0;
        while (!In_ready && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", {63'd0, In_ready}, 64'd1);
        Plain_in   = plain;
        Decrypt_in = dec;
        In_valid   = 1'b1;
        @(posedge clk);
        #1;
        In_valid   = 1'b0;
        @(negedge clk);
    endtask

    // Full block: per-round index/data checks, POST timing, result at edge T+17.
    task automatic run_block(input string tag, input logic [63:0] plain, input logic dec,
                             input logic tog, input logic [63:0] exp_cipher);
        logic [4:0] eidx;
        accept(plain, dec);
        chk({tag, "_busy"}, {63'd0, Busy}, 64'd1);
        chk({tag, "_inready_round"}, {63'd0, In_ready}, 64'd0);
        r_expw = plain;
        for (int i = 0; i < 16; i++) begin
            eidx = dec ? 5'(15 - i) : 5'(i);
            chk($sformatf("%s_idx%0d", tag, i), {59'd0, Rnd_idx_out}, {59'd0, eidx});
            chk($sformatf("%s_work%0d", tag, i), Rnd_data_out, r_expw);
            chk($sformatf("%s_ov%0d", tag, i), {63'd0, Out_valid}, 64'd0);
            r_expw = r_expw ^ {59'd0, eidx};
            if (tog) Decrypt_in = ~Decrypt_in;
            @(negedge clk);
        end
        chk({tag, "_post_ov"}, {63'd0, Out_valid}, 64'd0);
        chk({tag, "_post_idx"}, {59'd0, Rnd_idx_out}, 64'd0);
        chk({tag, "_post_data"}, Post_data_out, r_expw);
        @(negedge clk);
        chk({tag, "_done_ov"}, {63'd0, Out_valid}, 64'd1);
        chk({tag, "_cipher"}, Cipher_out, exp_cipher);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b1;
        In_valid   = 1'b0;
        Plain_in   = 64'd0;
        Decrypt_in = 1'b0;
        Out_ready  = 1'b1;

        // Reset values, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_inready", {63'd0, In_ready}, 64'd1);
        chk("rst_ov", {63'd0, Out_valid}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_idx", {59'd0, Rnd_idx_out}, 64'd0);
        chk("rst_rdata", Rnd_data_out, 64'd0);
        chk("rst_pdata", Post_data_out, 64'd0);
        chk("rst_cipher", Cipher_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Encrypt; accepted on the first rising edge after reset release.
        run_block("enc", 64'h0123456789ABCDEF, 1'b0, 1'b0, 64'h89ABCDEF01234567);
        @(negedge clk);
        chk("enc_ov_drop", {63'd0, Out_valid}, 64'd0);
        chk("enc_idle_ready", {63'd0, In_ready}, 64'd1);

        // Decrypt with Decrypt_in toggling during ROUND.
        run_block("dec", 64'h0123456789ABCDEF, 1'b1, 1'b1, 64'h89ABCDEF01234567);
        @(negedge clk);
        chk("dec_ov_drop", {63'd0, Out_valid}, 64'd0);

        // Downstream stall for 10 cycles with stray In_valid pulses.
        Out_ready = 1'b0;
        run_block("stall", 64'hDEADBEEF00C0FFEE, 1'b0, 1'b0, 64'h00C0FFEEDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            In_valid = i[0];
            Plain_in = 64'h5555AAAA5555AAAA;
            @(negedge clk);
            chk($sformatf("stall_ov%0d", i), {63'd0, Out_valid}, 64'd1);
            chk($sformatf("stall_cipher%0d", i), Cipher_out, 64'h00C0FFEEDEADBEEF);
            chk($sformatf("stall_inready%0d", i), {63'd0, In_ready}, 64'd0);
        end
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_ov", {63'd0, Out_valid}, 64'd0);
        chk("stall_release_ready", {63'd0, In_ready}, 64'd1);
        chk("stall_release_busy", {63'd0, Busy}, 64'd0);

        // Back-to-back with In_valid held high.
        Decrypt_in = 1'b0;
        Plain_in   = 64'hFEDCBA9876543210;
        In_valid   = 1'b1;
        n_acc      = 0;
        n_out      = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc_now = In_valid && In_ready;
            if (acc_now) begin
                if (n_acc < 2) acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (Out_valid) begin
                if (n_out < 2) outs[n_out] = Cipher_out;
                n_out++;
            end
            @(posedge clk);
            #1;
            if (acc_now && n_acc == 1) Plain_in = 64'h0000000100000002;
            if (acc_now && n_acc == 2) In_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_nacc", 64'(n_acc), 64'd2);
        chk("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd19);
        chk("b2b_nout", 64'(n_out), 64'd2);
        chk("b2b_out0", outs[0], 64'h76543210FEDCBA98);
        chk("b2b_out1", outs[1], 64'h0000000200000001);

        // Reset pulsed mid-ROUND at k=7.
        accept(64'h1122334455667788, 1'b0);
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("mid_idx7", {59'd0, Rnd_idx_out}, 64'd7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inready", {63'd0, In_ready}, 64'd1);
        chk("mid_rst_ov", {63'd0, Out_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, Busy}, 64'd0);
        chk("mid_rst_idx", {59'd0, Rnd_idx_out}, 64'd0);
        chk("mid_rst_rdata", Rnd_data_out, 64'd0);
        chk("mid_rst_pdata", Post_data_out, 64'd0);
        chk("mid_rst_cipher", Cipher_out, 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (Out_valid) ov_seen++;
        end
        chk("mid_no_ov", 64'(ov_seen), 64'd0);
        run_block("after_rst", 64'hA5A5A5A5C3C3C3C3, 1'b0, 1'b0, 64'hC3C3C3C3A5A5A5A5);
        @(negedge clk);
        chk("after_rst_ov_drop", {63'd0, Out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blowfish_round_seq.md
BLOWFISH_ROUND_SEQ -- requirements
Module: blowfish_round_seq

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous, active-low reset; only clock and reset in the block.
REQ-003 In_valid  input  1  upstream block presented on Plain_in.
REQ-004 In_ready  output  1  sequencer can accept a block this cycle.
REQ-005 Plain_in  input  64  plaintext or ciphertext block.
REQ-006 Decrypt_in  input  1  direction for the block; sampled on acceptance.
REQ-007 Rnd_data_out  output  64  working block driven to the shared single-round unit.
REQ-008 Rnd_idx_out  output  5  round index driven to the shared round unit.
REQ-009 Rnd_data_in  input  64  combinational result of the shared round unit.
REQ-010 Post_data_out  output  64  working block driven to the post-processing unit.
REQ-011 Post_data_in  input  64  combinational result of the post-processing unit.
REQ-012 Out_valid  output  1  Cipher_out holds a finished block.
REQ-013 Out_ready  input  1  downstream accepts Cipher_out.
REQ-014 Cipher_out  output  64  registered result block.
REQ-015 Busy  output  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, ROUND, POST, DONE; state encoding is free.
REQ-017 IDLE: In_ready=1; accept on In_valid&In_ready, load work register with Plain_in, latch Decrypt_in, clear round counter k, go to ROUND.
REQ-018 ROUND: each cycle, work register <= Rnd_data_in and k <= k+1; after the edge capturing k=15, go to POST.
REQ-019 k is a 4-bit counter; Rnd_idx_out = {1'b0,k} for encrypt, {1'b0,15-k} for decrypt.
REQ-020 Rnd_data_out = work register in all states; Rnd_idx_out = 5'd0 outside ROUND.
REQ-021 POST: one cycle; Cipher_out <= Post_data_in; go to DONE.
REQ-022 Post_data_out = work register in all states.
REQ-023 DONE: Out_valid=1; Cipher_out stable while Out_valid=1 and Out_ready=0.
REQ-024 DONE with Out_ready=1: return to IDLE; Out_valid low next cycle.
REQ-025 Latency: acceptance at edge T -> Out_valid high after edge T+17; exactly 16 ROUND cycles and 1 POST cycle per block.
REQ-026 In_ready=0 in ROUND, POST and DONE; In_valid in those states is ignored and never latched.
REQ-027 No overlap: a new block is accepted only in IDLE, at earliest the cycle after the Out_ready handshake; throughput is one block per 19 cycles with Out_ready tied high.
REQ-028 Out_valid held high in DONE indefinitely without Out_ready; no timeout.
REQ-029 Decrypt_in changes after acceptance do not affect the block in flight.

Reset
REQ-030 rst_n low asynchronously forces IDLE, k=0, work register=0, Cipher_out=0, direction=encrypt.
REQ-031 Outputs under reset: In_ready=1 (gated by rst_n), Out_valid=0, Busy=0, Rnd_idx_out=0, Rnd_data_out=0, Post_data_out=0.
REQ-032 Reset asserted mid-ROUND or mid-DONE discards the block; no Out_valid for it after reset release.
REQ-033 First acceptance is possible on the first rising edge with rst_n high.

Verification
REQ-034 Encrypt, Out_ready=1, Plain_in=64'h0123456789ABCDEF, bench round model = XOR with {59'd0,idx}: Rnd_idx_out 0..15 on consecutive cycles; Out_valid high after edge T+17; Cipher_out = post-model of final work value.
REQ-035 Decrypt same block: Rnd_idx_out sequence 15,14,..,0; latency unchanged at 17 edges.
REQ-036 Out_ready=0 for 10 cycles in DONE: Out_valid and Cipher_out stable for all 10; In_ready=0; In_valid pulses ignored; handshake returns to IDLE.
REQ-037 Back-to-back: In_valid held high, Out_ready=1, two blocks: second accepted exactly 19 cycles after the first; both results correct and ordered.
REQ-038 rst_n pulsed low while k=7: outputs take REQ-031 values immediately; no Out_valid afterward; next block completes normally with full 17-edge latency.
REQ-039 Decrypt_in toggled every cycle during ROUND: index direction remains that latched at acceptance.
